// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC result streamer: sweep FSM encoding and
// the supported result-memory read latency range.
package mfcc_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
endpackage

// File: rtl/mfcc_tag_fifo.sv
// Small synchronous FIFO holding result words with their address tags.
// Accepts a write while full when a read happens in the same cycle.
module mfcc_tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // depth need not be a power of two, so pointers wrap explicitly
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= nxt(wr_ptr);
      if (do_rd) rd_ptr <= nxt(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/mfcc_result_streamer.sv
// Sweeps the MFCC result memory frame by frame, coefficient by coefficient,
// and streams the words out on a valid/ready port with frame/coef/last tags.
module mfcc_result_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_AW   = 8,
  parameter int COEF_AW    = 6,
  parameter int RD_LAT     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [FRAME_AW-1:0]         first_frame,
  input  logic [FRAME_AW-1:0]         last_frame,
  input  logic [COEF_AW-1:0]          coef_last,
  output logic                        mem_rd_en,
  output logic [FRAME_AW+COEF_AW-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [FRAME_AW-1:0]         out_frame,
  output logic [COEF_AW-1:0]          out_coef,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);
  import mfcc_pkg::*;

  localparam int DEPTH = RD_LAT + 1;
  localparam int TAG_W = FRAME_AW + COEF_AW + 1;
  localparam int FW    = DATA_WIDTH + TAG_W;
  localparam int CW    = $clog2(DEPTH + 1);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mfcc_result_streamer: RD_LAT outside supported range");
  end

  state_t                          state;
  logic [FRAME_AW-1:0]             frame_cnt, last_frame_q;
  logic [COEF_AW-1:0]              coef_cnt, coef_last_q;
  logic                            cfg_err_q, at_end, credit_ok, pop;
  logic [TAG_W-1:0]                rd_tag;
  logic [RD_LAT-1:0]               vld_pipe;
  logic [RD_LAT-1:0][TAG_W-1:0]    tag_pipe;
  logic [FW-1:0]                   head;
  logic                            fifo_empty;
  logic [CW-1:0]                   fifo_cnt;
  int                              inflight;

  assign at_end = (frame_cnt == last_frame_q) && (coef_cnt == coef_last_q);
  assign rd_tag = {frame_cnt, coef_cnt, at_end};

  // in-flight count includes the word landing in the FIFO this cycle
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(vld_pipe[i]);
  end

  // a word leaving this cycle frees its slot for a read issued this cycle
  assign credit_ok = (int'(fifo_cnt) + inflight) < (DEPTH + int'(pop));

  assign mem_rd_en = !rst && (state == ST_RUN) && credit_ok;
  assign mem_addr  = mem_rd_en ? {frame_cnt, coef_cnt} : '0;
  assign out_valid = !rst && !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head[FW-1 -: DATA_WIDTH]  : '0;
  assign out_frame = out_valid ? head[TAG_W-1 -: FRAME_AW] : '0;
  assign out_coef  = out_valid ? head[COEF_AW:1]           : '0;
  assign out_last  = out_valid && head[0];
  assign done      = pop && head[0] && (state == ST_DRAIN);
  assign busy      = !rst && (state != ST_IDLE);
  assign cfg_err   = !rst && cfg_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      frame_cnt    <= '0;
      coef_cnt     <= '0;
      last_frame_q <= '0;
      coef_last_q  <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          if (first_frame > last_frame) begin
            cfg_err_q <= 1'b1;
          end else begin
            state        <= ST_RUN;
            frame_cnt    <= first_frame;
            coef_cnt     <= '0;
            last_frame_q <= last_frame;
            coef_last_q  <= coef_last;
          end
        end
        ST_RUN: if (mem_rd_en) begin
          if (at_end) begin
            state <= ST_DRAIN;
          end else if (coef_cnt == coef_last_q) begin
            coef_cnt  <= '0;
            frame_cnt <= frame_cnt + 1'b1;
          end else begin
            coef_cnt <= coef_cnt + 1'b1;
          end
        end
        ST_DRAIN: if (done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // clearing vld_pipe on reset drops reads still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= mem_rd_en;
      tag_pipe[0] <= rd_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  mfcc_tag_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_pipe[RD_LAT-1]),
    .wr_data ({mem_rdata, tag_pipe[RD_LAT-1]}),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );
endmodule

// File: tb/tb_mfcc_result_streamer.sv
// Directed bench: two streamers (read latency 1 and 3) share stimulus; each
// has its own result-memory model and in-order scoreboard.
module tb_mfcc_result_streamer;
  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [7:0] first_frame, last_frame;
  logic [5:0] coef_last;
  logic [1:0] mem_rd_en, out_valid, out_last, busy, done, cfg_err;
  logic [1:0][13:0] mem_addr;
  logic [1:0][31:0] mem_rdata, out_data;
  logic [1:0][7:0]  out_frame;
  logic [1:0][5:0]  out_coef;

  always #5 clk = ~clk;

  mfcc_result_streamer #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .first_frame(first_frame),
    .last_frame(last_frame), .coef_last(coef_last), .mem_rd_en(mem_rd_en[0]),
    .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_data(out_data[0]), .out_frame(out_frame[0]),
    .out_coef(out_coef[0]), .out_last(out_last[0]), .busy(busy[0]),
    .done(done[0]), .cfg_err(cfg_err[0]));

  mfcc_result_streamer #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .first_frame(first_frame),
    .last_frame(last_frame), .coef_last(coef_last), .mem_rd_en(mem_rd_en[1]),
    .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_data(out_data[1]), .out_frame(out_frame[1]),
    .out_coef(out_coef[1]), .out_last(out_last[1]), .busy(busy[1]),
    .done(done[1]), .cfg_err(cfg_err[1]));

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {18'h2B1C5, a};
  endfunction

  // result memories: data appears RD_LAT cycles after the address
  logic [13:0] a1;
  logic [2:0][13:0] a3;
  always @(posedge clk) begin
    a1 <= mem_addr[0];
    a3 <= {a3[1:0], mem_addr[1]};
  end
  assign mem_rdata[0] = mem_word(a1);
  assign mem_rdata[1] = mem_word(a3[2]);

  typedef struct {
    int first, last, cl;
    bit rnd, mid;
    int exp_words;
  } vec_t;
  vec_t vecs[6];

  int tests = 0, fails = 0, cyc = 0, start_cyc = 0;
  int cur_first, cur_last, cur_cl, exp_total;
  bit chk_en = 0, ready_rnd = 0;
  int rd_f[2], rd_c[2], ex_f[2], ex_c[2], words[2], rd_cnt[2], done_cnt[2];
  int cfg_cnt[2], first_cyc[2], gaps[2];
  bit busy_seen[2], stalled[2];
  logic [46:0] held[2];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic advance(inout int f, inout int c);
    if (c == cur_cl) begin c = 0; f++; end else c++;
  endtask

  task automatic observe(input int d);
    logic [46:0] cur, exp_w;
    bit exp_last;
    cur = {out_data[d], out_frame[d], out_coef[d], out_last[d]};
    if (busy[d]) busy_seen[d] = 1;
    if (cfg_err[d]) cfg_cnt[d]++;
    if (mem_rd_en[d]) begin
      chk($sformatf("rd_addr[%0d]", d), 80'(mem_addr[d]), 80'({8'(rd_f[d]), 6'(rd_c[d])}));
      rd_cnt[d]++;
      advance(rd_f[d], rd_c[d]);
    end
    if (stalled[d]) chk($sformatf("stall_hold[%0d]", d), 80'({out_valid[d], cur}), 80'({1'b1, held[d]}));
    if (out_valid[d] && first_cyc[d] < 0) begin
      first_cyc[d] = cyc;
      if (!ready_rnd) chk($sformatf("first_lat[%0d]", d), 80'(cyc - start_cyc), 80'(d ? 5 : 3));
    end
    exp_last = (ex_f[d] == cur_last) && (ex_c[d] == cur_cl);
    if (out_valid[d] && out_ready) begin
      exp_w = {mem_word({8'(ex_f[d]), 6'(ex_c[d])}), 8'(ex_f[d]), 6'(ex_c[d]), exp_last};
      chk($sformatf("word[%0d]", d), 80'(cur), 80'(exp_w));
      chk($sformatf("done_pulse[%0d]", d), 80'(done[d]), 80'(exp_last));
      advance(ex_f[d], ex_c[d]);
      words[d]++;
    end else begin
      if (done[d]) chk($sformatf("done_no_xfer[%0d]", d), 80'(done[d]), 80'(0));
      if (!ready_rnd && words[d] > 0 && words[d] < exp_total) gaps[d]++;
    end
    if (done[d]) done_cnt[d]++;
    stalled[d] = out_valid[d] && !out_ready;
    held[d] = cur;
  endtask

  task automatic step(input bit st = 0, input bit rs = 0, input bit scr = 0);
    @(negedge clk);
    start = st;
    rst = rs;
    out_ready = ready_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (scr) begin
      first_frame = 8'($urandom);
      last_frame  = 8'($urandom);
      coef_last   = 6'($urandom);
    end
    #1;
    cyc++;
    if (chk_en) for (int d = 0; d < 2; d++) observe(d);
  endtask

  task automatic zero_chk(input string name);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s[%0d]", name, d),
          80'({mem_rd_en[d], mem_addr[d], out_valid[d], out_data[d], out_frame[d],
               out_coef[d], out_last[d], busy[d], done[d], cfg_err[d]}), 80'(0));
  endtask

  task automatic run_sweep(input vec_t v);
    int budget;
    cur_first = v.first; cur_last = v.last; cur_cl = v.cl;
    exp_total = v.exp_words;
    ready_rnd = v.rnd;
    for (int d = 0; d < 2; d++) begin
      rd_f[d] = v.first; rd_c[d] = 0; ex_f[d] = v.first; ex_c[d] = 0;
      words[d] = 0; rd_cnt[d] = 0; done_cnt[d] = 0; cfg_cnt[d] = 0;
      first_cyc[d] = -1; gaps[d] = 0; busy_seen[d] = 0; stalled[d] = 0;
    end
    first_frame = 8'(v.first); last_frame = 8'(v.last); coef_last = 6'(v.cl);
    chk_en = 1;
    step(1);
    start_cyc = cyc;
    budget = v.exp_words * 3 + 60;
    for (int n = 0; n < budget; n++) begin
      step(v.mid && n == 5, 0, 1);
      if (v.exp_words == 0 && n >= 20) break;
      if (v.exp_words > 0 && done_cnt[0] > 0 && done_cnt[1] > 0) break;
    end
    repeat (3) step(0, 0, 1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("words[%0d]", d), 80'(words[d]), 80'(v.exp_words));
      chk($sformatf("reads[%0d]", d), 80'(rd_cnt[d]), 80'(v.exp_words));
      chk($sformatf("done_cnt[%0d]", d), 80'(done_cnt[d]), 80'(v.exp_words > 0));
      chk($sformatf("cfg_err_cnt[%0d]", d), 80'(cfg_cnt[d]), 80'(v.exp_words == 0));
      chk($sformatf("busy_seen[%0d]", d), 80'(busy_seen[d]), 80'(v.exp_words > 0));
      if (!v.rnd && v.exp_words > 0) chk($sformatf("gaps[%0d]", d), 80'(gaps[d]), 80'(0));
    end
    zero_chk("idle_after");
    chk_en = 0;
  endtask

  initial begin
    vecs[0] = '{first: 2,   last: 21,  cl: 63, rnd: 0, mid: 1, exp_words: 1280};
    vecs[1] = '{first: 2,   last: 21,  cl: 63, rnd: 1, mid: 1, exp_words: 1280};
    vecs[2] = '{first: 5,   last: 4,   cl: 3,  rnd: 0, mid: 0, exp_words: 0};
    vecs[3] = '{first: 7,   last: 7,   cl: 0,  rnd: 0, mid: 0, exp_words: 1};
    vecs[4] = '{first: 254, last: 255, cl: 2,  rnd: 0, mid: 0, exp_words: 6};
    vecs[5] = '{first: 0,   last: 0,   cl: 63, rnd: 1, mid: 0, exp_words: 64};

    start = 0; rst = 1; out_ready = 1;
    first_frame = 0; last_frame = 0; coef_last = 0;
    step(0, 1);
    step(0, 1);
    zero_chk("in_reset");
    step(0, 0);
    zero_chk("idle_reset");

    for (int i = 0; i < 6; i++) run_sweep(vecs[i]);

    // reset 10 cycles into a latency-3 sweep; nothing stale may surface
    ready_rnd = 0;
    first_frame = 0; last_frame = 3; coef_last = 63;
    step(1);
    repeat (9) step(0);
    step(0, 1);
    zero_chk("mid_rst");
    step(0, 0);
    zero_chk("post_rst");
    for (int n = 0; n < 8; n++) begin
      step(0, 0);
      chk("no_stale", 80'({out_valid, mem_rd_en, busy}), 80'(0));
    end
    run_sweep('{first: 10, last: 11, cl: 5, rnd: 1, mid: 0, exp_words: 12});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
